dcache_mem_responder: RTL and testbench
=======================================

# dcache_mem_responder

Memory-side responder for the L1 data cache's D_* request interface, the target end of the cache's miss/write-through traffic. It accepts one request at a time and serves single-beat masked writes (byte/half/word) and four-beat line reads (line fill). Data lives in a word-addressed local store. Response latency and beat spacing are configurable, so the cache can be exercised against slow memory in simulation and used as a tightly coupled data RAM in small builds.

## Interface
- LAT_READ, 2: idle cycles between read acceptance and beat 0 (0 allowed).
- LAT_WRITE, 1: idle cycles between write acceptance and write completion (0 allowed).
- BEAT_GAP, 0: idle cycles between consecutive read beats.
- ADDR_W, 14: log2 of store depth in 32-bit words (default 64 KiB).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- D_req  in  1  request valid; held by cache until its request completes.
- D_addr  in  32  byte address; bits [ADDR_W+1:2] index the store; higher bits ignored (alias).
- D_write  in  1  1 = write, 0 = line read.
- D_in  in  32  write data, already lane-positioned; no shifting.
- D_type  in  3  `CACHE_BYTE / `CACHE_HWORD / `CACHE_WORD (bits [1:0]); ignored on reads.
- D_out  out  32  read beat data (registered).
- D_wait  out  1  low for exactly one cycle per completed beat/write; high otherwise.

## Operation
- FSM states: IDLE, RLAT, RBEAT, RGAP, WLAT, WDONE, DONE.
- IDLE: D_wait=1. On D_req=1 at an edge, capture D_addr, D_in, D_type, D_write, and load the latency counter.
  - Read: base = {D_addr[ADDR_W+1:4], 2'b00} (D_addr[3:0] forced to 0); beat counter = 0; go to RLAT (or directly to RBEAT if LAT_READ=0).
  - Write: go to WLAT (or directly to WDONE if LAT_WRITE=0).
- RLAT: decrement the counter each cycle; go to RBEAT when it reaches 0.
- RBEAT: D_wait=0; D_out = store[base + beat].
  - beat==3: go to DONE.
  - Otherwise: beat+1, then RGAP (BEAT_GAP>0) or stay in RBEAT (back-to-back).
- RGAP: D_wait=1 for BEAT_GAP cycles, then RBEAT.
- D_out holds its last value outside RBEAT.
- Beat order is always 0,1,2,3 from the line base; the beat counter is 2 bits, so the address never leaves the line.
- WLAT: count LAT_WRITE cycles, then go to WDONE.
- WDONE: D_wait=0; the store is updated at the end of this cycle under the byte strobe; go to DONE.
- Byte strobe:
  - byte: 4'b0001 << addr[1:0].
  - hword: addr[1] ? 4'b1100 : 4'b0011 (addr[0] ignored).
  - word, or any other type value: 4'b1111.
- DONE: one cycle with D_wait=1, and D_req is ignored. This absorbs the cache's one-cycle-late D_req deassert. Then go to IDLE.
- D_req, D_addr and D_type changing after acceptance are ignored. Only the captured copies are used.
- The store is not reset and is not cleared by rst.

## Timing
- Acceptance edge defines cycle T; the accepting cycle itself has D_wait=1.
- Read beat k: D_wait low in cycle T+1+LAT_READ+k*(BEAT_GAP+1).
- Write: D_wait low in cycle T+1+LAT_WRITE; the write is visible to any later-accepted read.
- Earliest next acceptance: the edge ending the DONE cycle, i.e. DONE+1 is IDLE, and a D_req held high there is accepted.
- Reset values: D_wait=1, D_out=0, FSM=IDLE, counters=0.
- Reset asserted mid-transaction aborts it. A write aborted before WDONE does not modify the store. Remaining read beats are dropped.

## Configuration
- DCACHE_MEM_RESP_STATS_EN defined: adds 32-bit counters rd_lines, wr_reqs and wait_cycles.
  - wait_cycles counts cycles with D_req=1 and D_wait=1 outside DONE.
  - All three reset to 0, saturate at 32'hFFFFFFFF, and are readable hierarchically.
- Undefined: the counters and their logic are absent; port behaviour is identical.

## Test plan
- Reset, then idle 10 cycles -> D_wait=1 and D_out=0 throughout; no state change with D_req=0.
- Preload store[0x40..0x43] = 11,22,33,44; read at D_addr=0x104 with LAT_READ=2, BEAT_GAP=0 -> D_wait low in T+3..T+6 with D_out = 11,22,33,44; DONE at T+7; D_req still high at T+7 is ignored.
- Word 0x200 = 0xAABBCCDD; byte write of D_in=0x00EE0000 at addr 0x202 -> word becomes 0xAAEECCDD. Then hword write of 0x12340000 at 0x203 -> word becomes 0x1234CCDD.
- LAT_WRITE=0 word write 0xDEADBEEF at 0x300, followed by a read of line 0x300 -> write D_wait low at T+1; read beat 0 returns 0xDEADBEEF.
- BEAT_GAP=2 read -> beats at T+1+LAT_READ+{0,3,6,9}; D_wait high in the gap cycles; D_out holds the previous beat.
- rst pulsed after beat 1 of a read, and separately during WLAT -> D_wait=1, FSM=IDLE, D_out=0; the aborted write leaves the word unchanged; the next request is served normally.

Source files
------------

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the L1 D-cache D_* port: masked single-beat writes, 4-beat line reads.
// Define DCACHE_MEM_RESP_STATS_EN to add the rd_lines / wr_reqs / wait_cycles counters.
`ifndef CACHE_BYTE
`define CACHE_BYTE 3'd0
`endif
`ifndef CACHE_HWORD
`define CACHE_HWORD 3'd1
`endif
`ifndef CACHE_WORD
`define CACHE_WORD 3'd2
`endif

module dcache_mem_responder #(
  parameter int LAT_READ  = 2,
  parameter int LAT_WRITE = 1,
  parameter int BEAT_GAP  = 0,
  parameter int ADDR_W    = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        D_req,
  input  logic [31:0] D_addr,
  input  logic        D_write,
  input  logic [31:0] D_in,
  input  logic [2:0]  D_type,
  output logic [31:0] D_out,
  output logic        D_wait
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RLAT  = 3'd1;
  localparam logic [2:0] RBEAT = 3'd2;
  localparam logic [2:0] RGAP  = 3'd3;
  localparam logic [2:0] WLAT  = 3'd4;
  localparam logic [2:0] WDONE = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LAT_R_C = CNT_W'(LAT_READ);
  localparam logic [CNT_W-1:0] LAT_W_C = CNT_W'(LAT_WRITE);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(BEAT_GAP);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  localparam logic [1:0] T_BYTE  = 2'(`CACHE_BYTE);
  localparam logic [1:0] T_HWORD = 2'(`CACHE_HWORD);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        beat;
  logic [ADDR_W-3:0] line;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic [3:0]        strb, strb_new;
  logic [ADDR_W-3:0] rd_line;
  logic [1:0]        rd_beat;
  logic              unused_bits;

  assign unused_bits = ^{D_addr[31:ADDR_W+2], D_type[2]};
  assign D_wait = !(state == RBEAT || state == WDONE);

  always_comb begin
    strb_new = 4'b1111;
    case (D_type[1:0])
      T_BYTE:  strb_new = 4'b0001 << D_addr[1:0];
      T_HWORD: strb_new = D_addr[1] ? 4'b1100 : 4'b0011;
      default: strb_new = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (D_req) begin
          if (D_write) state_nxt = (LAT_WRITE == 0) ? WDONE : WLAT;
          else         state_nxt = (LAT_READ == 0) ? RBEAT : RLAT;
        end
      end
      RLAT:    if (cnt == ONE_C) state_nxt = RBEAT;
      RBEAT:   state_nxt = (beat == 2'd3) ? DONE : ((BEAT_GAP == 0) ? RBEAT : RGAP);
      RGAP:    if (cnt == ONE_C) state_nxt = RBEAT;
      WLAT:    if (cnt == ONE_C) state_nxt = WDONE;
      WDONE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word to present on the next beat: the beat counter only advances when a beat is left.
  always_comb begin
    rd_line = line;
    rd_beat = beat;
    if (state == IDLE) begin
      rd_line = D_addr[ADDR_W+1:4];
      rd_beat = 2'd0;
    end else if (state == RBEAT) begin
      rd_beat = beat + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      beat  <= 2'd0;
      line  <= '0;
      waddr <= '0;
      wdata <= '0;
      strb  <= 4'b0000;
      D_out <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (D_req) begin
            beat  <= 2'd0;
            line  <= D_addr[ADDR_W+1:4];
            waddr <= D_addr[ADDR_W+1:2];
            wdata <= D_in;
            strb  <= strb_new;
            cnt   <= D_write ? LAT_W_C : LAT_R_C;
          end
        end
        RLAT, RGAP, WLAT: cnt <= cnt - ONE_C;
        RBEAT: begin
          if (beat != 2'd3) begin
            beat <= beat + 2'd1;
            cnt  <= GAP_C;
          end
        end
        default: ;
      endcase
      if (state_nxt == RBEAT) D_out <= mem[{rd_line, rd_beat}];
    end
  end

  // The store has no reset; a write aborted by rst never reaches WDONE.
  always_ff @(posedge clk) begin
    if (state == WDONE) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

`ifdef DCACHE_MEM_RESP_STATS_EN
  logic [31:0] rd_lines, wr_reqs, wait_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_lines    <= 32'd0;
      wr_reqs     <= 32'd0;
      wait_cycles <= 32'd0;
    end else begin
      if (state == IDLE && D_req && !D_write && rd_lines != 32'hFFFFFFFF)
        rd_lines <= rd_lines + 32'd1;
      if (state == IDLE && D_req && D_write && wr_reqs != 32'hFFFFFFFF)
        wr_reqs <= wr_reqs + 32'd1;
      if (D_req && D_wait && state != DONE && wait_cycles != 32'hFFFFFFFF)
        wait_cycles <= wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Self-checking bench for dcache_mem_responder: two instances with different latency/gap settings,
// a directed vector table, reset-abort sequences and randomized traffic against a word-array model.
`ifndef CACHE_BYTE
`define CACHE_BYTE 3'd0
`endif
`ifndef CACHE_HWORD
`define CACHE_HWORD 3'd1
`endif
`ifndef CACHE_WORD
`define CACHE_WORD 3'd2
`endif

module tb_dcache_mem_responder;

  localparam int LR_A = 2, LW_A = 1, G_A = 0, AW_A = 14;
  localparam int LR_B = 0, LW_B = 0, G_B = 2, AW_B = 10;
  localparam logic [1:0] TB_BYTE  = 2'(`CACHE_BYTE);
  localparam logic [1:0] TB_HWORD = 2'(`CACHE_HWORD);
  localparam int NV = 17;

  typedef struct {
    bit               wr;
    logic [31:0]      addr;
    logic [31:0]      din;
    logic [2:0]       typ;
    logic [3:0]       mask;
    logic [3:0][31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_v  [2];
  logic        req_v  [2];
  logic [31:0] addr_v [2];
  logic        wr_v   [2];
  logic [31:0] din_v  [2];
  logic [2:0]  typ_v  [2];
  logic [31:0] out_v  [2];
  logic        wait_v [2];

  logic [31:0] model [2][16384];
  vec_t        vecs [NV];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dcache_mem_responder #(.LAT_READ(LR_A), .LAT_WRITE(LW_A), .BEAT_GAP(G_A), .ADDR_W(AW_A)) dut_a (
    .clk(clk), .rst(rst_v[0]), .D_req(req_v[0]), .D_addr(addr_v[0]), .D_write(wr_v[0]),
    .D_in(din_v[0]), .D_type(typ_v[0]), .D_out(out_v[0]), .D_wait(wait_v[0])
  );

  dcache_mem_responder #(.LAT_READ(LR_B), .LAT_WRITE(LW_B), .BEAT_GAP(G_B), .ADDR_W(AW_B)) dut_b (
    .clk(clk), .rst(rst_v[1]), .D_req(req_v[1]), .D_addr(addr_v[1]), .D_write(wr_v[1]),
    .D_in(din_v[1]), .D_type(typ_v[1]), .D_out(out_v[1]), .D_wait(wait_v[1])
  );

  function automatic int aw_of(input int sel);
    return (sel == 0) ? AW_A : AW_B;
  endfunction

  function automatic int widx(input int sel, input logic [31:0] addr);
    logic [31:0] m;
    m = (32'd1 << aw_of(sel)) - 32'd1;
    return int'((addr >> 2) & m);
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] din,
                              input logic [2:0] typ, input logic [3:0] mask,
                              input logic [3:0][31:0] exp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.din = din; v.typ = typ; v.mask = mask; v.exp = exp;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic req, input logic wr,
                                input logic [31:0] addr, input logic [31:0] din, input logic [2:0] typ);
    req_v[sel]  = req;
    wr_v[sel]   = wr;
    addr_v[sel] = addr;
    din_v[sel]  = din;
    typ_v[sel]  = typ;
  endtask

  // Byte-lane merge straight from the strobe rules: byte, half (addr[0] ignored), else whole word.
  task automatic model_write(input int sel, input logic [31:0] addr, input logic [31:0] din,
                             input logic [2:0] typ);
    int          idx;
    logic [31:0] w;
    bit          en;
    idx = widx(sel, addr);
    w = model[sel][idx];
    for (int j = 0; j < 4; j++) begin
      if (typ[1:0] == TB_BYTE)       en = (j == int'(addr[1:0]));
      else if (typ[1:0] == TB_HWORD) en = ((j / 2) == int'(addr[1]));
      else                           en = 1'b1;
      if (en) w[8*j +: 8] = din[8*j +: 8];
    end
    model[sel][idx] = w;
  endtask

  // Entered just after a rising edge; returns just after a rising edge in the cycle after DONE
  // (hold=1 leaves D_req high there so the next call is accepted at the earliest legal edge).
  task automatic run_txn(input int sel, input bit wr, input logic [31:0] addr, input logic [31:0] din,
                         input logic [2:0] typ, input bit hold, output logic [3:0][31:0] got);
    int               first, last, done_c, step, k, base;
    bit               bad, exp_low;
    logic [3:0][31:0] exp;
    base = widx(sel, addr) & ~3;
    for (int i = 0; i < 4; i++) exp[i] = model[sel][base + i];
    step   = ((sel == 0) ? G_A : G_B) + 1;
    first  = 1 + (wr ? ((sel == 0) ? LW_A : LW_B) : ((sel == 0) ? LR_A : LR_B));
    last   = wr ? first : first + 3 * step;
    done_c = last + 1;
    got = '0;
    bad = 1'b0;
    apply_stimulus(sel, 1'b1, wr, addr, din, typ);
    @(posedge clk); #1;
    apply_stimulus(sel, 1'b1, 1'($urandom), $urandom, $urandom, 3'($urandom));
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      exp_low = (c >= first) && (c <= last) && (((c - first) % step) == 0);
      if (wait_v[sel] !== !exp_low) bad = 1'b1;
      if (!wr && exp_low) begin
        k = (c - first) / step;
        got[k] = out_v[sel];
        check_output($sformatf("beat%0d_inst%0d", k, sel), out_v[sel], exp[k]);
      end else if (!wr && c > first && c <= last) begin
        k = (c - first) / step;
        if (out_v[sel] !== exp[k]) bad = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!hold) begin
      apply_stimulus(sel, 1'b0, 1'($urandom), $urandom, $urandom, 3'($urandom));
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (wait_v[sel] !== 1'b1) bad = 1'b1;
        if (!wr && out_v[sel] !== exp[3]) bad = 1'b1;
        @(posedge clk); #1;
      end
    end
    check_output($sformatf("timing_inst%0d_%s", sel, wr ? "wr" : "rd"), {31'd0, bad}, 32'd0);
    if (wr) model_write(sel, addr, din, typ);
  endtask

  initial begin
    logic [3:0][31:0] got;
    int               bad_cnt;
    logic [31:0]      hi, a;
    int               w;
    bit               wr, hold;

    vecs[0]  = mk(1, 32'h100, 32'h11, `CACHE_WORD, 4'h0, '0);
    vecs[1]  = mk(1, 32'h104, 32'h22, `CACHE_WORD, 4'h0, '0);
    vecs[2]  = mk(1, 32'h108, 32'h33, `CACHE_WORD, 4'h0, '0);
    vecs[3]  = mk(1, 32'h10C, 32'h44, `CACHE_WORD, 4'h0, '0);
    vecs[4]  = mk(0, 32'h104, 32'h0, `CACHE_WORD, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11});
    vecs[5]  = mk(1, 32'h200, 32'hAABBCCDD, `CACHE_WORD, 4'h0, '0);
    vecs[6]  = mk(1, 32'h202, 32'h00EE0000, `CACHE_BYTE, 4'h0, '0);
    vecs[7]  = mk(0, 32'h200, 32'h0, `CACHE_WORD, 4'h1, {96'd0, 32'hAAEECCDD});
    vecs[8]  = mk(1, 32'h203, 32'h12340000, `CACHE_HWORD, 4'h0, '0);
    vecs[9]  = mk(0, 32'h20C, 32'h0, `CACHE_BYTE, 4'h1, {96'd0, 32'h1234CCDD});
    vecs[10] = mk(1, 32'h300, 32'h01020304, `CACHE_WORD, 4'h0, '0);
    vecs[11] = mk(1, 32'h301, 32'hFFFFA5FF, `CACHE_BYTE, 4'h0, '0);
    vecs[12] = mk(1, 32'h300, 32'hFFFF9999, `CACHE_HWORD, 4'h0, '0);
    vecs[13] = mk(0, 32'h308, 32'h0, `CACHE_WORD, 4'h1, {96'd0, 32'h01029999});
    vecs[14] = mk(1, 32'h302, 32'h5A5A5A5A, 3'b011, 4'h0, '0);
    vecs[15] = mk(1, 32'h303, 32'h77000000, 3'b100, 4'h0, '0);
    vecs[16] = mk(0, 32'h300, 32'h0, `CACHE_WORD, 4'h1, {96'd0, 32'h775A5A5A});

    for (int s = 0; s < 2; s++) begin
      rst_v[s] = 1'b1;
      apply_stimulus(s, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    for (int s = 0; s < 2; s++) begin
      bad_cnt = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (wait_v[s] !== 1'b1 || out_v[s] !== 32'd0) bad_cnt++;
      end
      check_output($sformatf("reset_idle_inst%0d", s), bad_cnt, 32'd0);
    end
    @(posedge clk); #1;

    // Fill words 0..255 of both stores so every later read hits known data.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        hold = (i != 255) && ($urandom_range(0, 1) == 1);
        run_txn(s, 1'b1, 32'(i << 2), {8'(s), 8'(i), 16'($urandom)}, `CACHE_WORD, hold, got);
      end
    end

    for (int i = 0; i < NV; i++) begin
      run_txn(0, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].typ, 1'b0, got);
      for (int k = 0; k < 4; k++) begin
        if (!vecs[i].wr && vecs[i].mask[k])
          check_output($sformatf("vec%0d_beat%0d", i, k), got[k], vecs[i].exp[k]);
      end
    end

    // Zero-latency write immediately followed by a read of the same line on the gapped instance.
    run_txn(1, 1'b1, 32'h300, 32'hDEADBEEF, `CACHE_WORD, 1'b1, got);
    run_txn(1, 1'b0, 32'h300, 32'h0, `CACHE_WORD, 1'b0, got);
    check_output("b2b_deadbeef", got[0], 32'hDEADBEEF);

    // Reset after beat 1 of a read: remaining beats dropped, D_out cleared.
    apply_stimulus(0, 1'b1, 1'b0, 32'h104, 32'h0, `CACHE_WORD);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_output("abort_rd_beat1", out_v[0], 32'h22);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    #1;
    check_output("abort_rd_wait", {31'd0, wait_v[0]}, 32'd1);
    check_output("abort_rd_out", out_v[0], 32'd0);
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    bad_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wait_v[0] !== 1'b1 || out_v[0] !== 32'd0) bad_cnt++;
    end
    check_output("abort_rd_quiet", bad_cnt, 32'd0);
    @(posedge clk); #1;
    run_txn(0, 1'b0, 32'h108, 32'h0, `CACHE_WORD, 1'b0, got);
    check_output("after_abort_rd", got[1], 32'h22);

    // Reset during WLAT: the word must keep its previous value.
    apply_stimulus(0, 1'b1, 1'b1, 32'h200, 32'hFFFFFFFF, `CACHE_WORD);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    #1;
    check_output("abort_wr_wait", {31'd0, wait_v[0]}, 32'd1);
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    repeat (3) begin @(posedge clk); #1; end
    run_txn(0, 1'b0, 32'h200, 32'h0, `CACHE_WORD, 1'b0, got);
    check_output("abort_wr_unchanged", got[0], 32'h1234CCDD);

    // Randomized traffic with aliased high address bits and arbitrary type codes.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 150; n++) begin
        wr   = ($urandom_range(0, 1) == 1);
        w    = int'($urandom_range(0, 255));
        hi   = $urandom;
        a    = (hi << (aw_of(s) + 2)) | 32'(w << 2) | 32'($urandom_range(0, 3));
        hold = (n != 149) && ($urandom_range(0, 1) == 1);
        run_txn(s, wr, a, $urandom, 3'($urandom), hold, got);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
